// File: rtl/odometry_pose_integrator.sv
// odometry_pose_integrator
//   Integrates a planar pose (x, y, heading) from the cumulative left and
//   right wheel distances. Every SAMPLE_CYCLES clocks the wheel deltas are
//   taken, the heading change is derived from the wheel difference, and the
//   mean travel is rotated by the midpoint heading with an iterative CORDIC
//   before being added to x/y.
//
//   Optional build macro POSE_SATURATE_EN: x/y adds saturate to the int32
//   range and a sticky pose_sat output is added. Without it x/y wrap modulo
//   2^32.
//
// Ports
//   clk, reset             clock, asynchronous active-high reset
//   distance_pulse_left    cumulative left distance, mm (mod 2^32)
//   distance_pulse_right   cumulative right distance, mm (mod 2^32)
//   clear_pose             synchronous clear: zero pose, re-reference inputs
//   pose_x, pose_y         signed position, mm
//   pose_theta             signed heading, mrad, [-3142, 3141]
//   pose_valid             one-cycle strobe after each pose update
//   busy                   high whenever the FSM is not IDLE
//   pose_sat               (POSE_SATURATE_EN only) sticky x/y clamp flag
module odometry_pose_integrator #(
  parameter int SAMPLE_CYCLES = 500000,
  parameter int INV_WB_Q16    = 436907,
  parameter int CORDIC_ITER   = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] distance_pulse_left,
  input  logic [31:0] distance_pulse_right,
  input  logic        clear_pose,
  output logic [31:0] pose_x,
  output logic [31:0] pose_y,
  output logic [31:0] pose_theta,
  output logic        pose_valid,
  output logic        busy
`ifdef POSE_SATURATE_EN
  ,
  output logic        pose_sat
`endif
);

  localparam int CNT_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic signed [63:0] INV_WB = 64'(INV_WB_Q16);
  // 1/K CORDIC gain in Q16, applied to the travel before rotation
  localparam logic signed [63:0] K_PRE  = 64'sd39797;

  typedef enum logic [2:0] {IDLE, SAMPLE, DELTA, PREP, ROT, ACC} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [31:0]           prev_l, prev_r, dl, dr;
  logic signed [31:0]    d, dth, th_new;
  logic signed [39:0]    cx, cy, cz;
  logic                  neg;
  logic [4:0]            it;

  // round(atan(2^-i) * 256000): Q8 mrad
  function automatic logic signed [39:0] atan_q8(input logic [3:0] i);
    case (i)
      4'd0:  atan_q8 = 40'sd201062;
      4'd1:  atan_q8 = 40'sd118694;
      4'd2:  atan_q8 = 40'sd62715;
      4'd3:  atan_q8 = 40'sd31835;
      4'd4:  atan_q8 = 40'sd15979;
      4'd5:  atan_q8 = 40'sd7997;
      4'd6:  atan_q8 = 40'sd4000;
      4'd7:  atan_q8 = 40'sd2000;
      4'd8:  atan_q8 = 40'sd1000;
      4'd9:  atan_q8 = 40'sd500;
      4'd10: atan_q8 = 40'sd250;
      4'd11: atan_q8 = 40'sd125;
      4'd12: atan_q8 = 40'sd62;
      4'd13: atan_q8 = 40'sd31;
      4'd14: atan_q8 = 40'sd16;
      default: atan_q8 = 40'sd8;
    endcase
  endfunction

  // Single +/-2*pi correction; inputs never exceed one turn out of range.
  function automatic logic signed [31:0] wrap_mrad(input logic signed [31:0] v);
    if (v > 32'sd3141)       wrap_mrad = v - 32'sd6283;
    else if (v < -32'sd3142) wrap_mrad = v + 32'sd6283;
    else                     wrap_mrad = v;
  endfunction

`ifdef POSE_SATURATE_EN
  // {clamped, result}
  function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) sat_add = {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    else                sat_add = {1'b0, s[31:0]};
  endfunction
`endif

  assign tick = (cnt == CNT_W'(SAMPLE_CYCLES - 1));

  // ---------------- datapath (combinational) ----------------
  logic signed [32:0] sum_lr, diff_rl;
  logic signed [63:0] dth_raw;
  logic signed [31:0] d_c, dth_c, th_new_c, th_mid, th_fold;
  logic               fold;
  logic signed [39:0] x0, z0, sx, sy, at;
  logic signed [31:0] xr, yr;
  logic [31:0]        nx, ny;
`ifdef POSE_SATURATE_EN
  logic               hit_x, hit_y;
`endif

  always_comb begin
    sum_lr  = $signed({dl[31], dl}) + $signed({dr[31], dr});
    diff_rl = $signed({dr[31], dr}) - $signed({dl[31], dl});
    d_c     = 32'(sum_lr >>> 1);
    dth_raw = ($signed({{31{diff_rl[32]}}, diff_rl}) * INV_WB) >>> 16;
    if (dth_raw > 64'sd3141)       dth_c = 32'sd3141;
    else if (dth_raw < -64'sd3141) dth_c = -32'sd3141;
    else                           dth_c = 32'(dth_raw);

    th_new_c = wrap_mrad($signed(pose_theta) + dth);
    th_mid   = wrap_mrad($signed(pose_theta) + (dth >>> 1));
    // Fold into [-pi/2, pi/2] so the CORDIC converges; undo with a negate.
    fold    = 1'b0;
    th_fold = th_mid;
    if (th_mid > 32'sd1571) begin
      th_fold = th_mid - 32'sd3142;
      fold    = 1'b1;
    end else if (th_mid < -32'sd1571) begin
      th_fold = th_mid + 32'sd3142;
      fold    = 1'b1;
    end
    x0 = 40'(($signed({{32{d[31]}}, d}) * K_PRE) >>> 16);
    z0 = $signed({{8{th_fold[31]}}, th_fold}) <<< 8;

    sx = cy >>> it;
    sy = cx >>> it;
    at = atan_q8(it[3:0]);

    xr = 32'(neg ? -cx : cx);
    yr = 32'(neg ? -cy : cy);
`ifdef POSE_SATURATE_EN
    {hit_x, nx} = sat_add(pose_x, xr);
    {hit_y, ny} = sat_add(pose_y, yr);
`else
    nx = pose_x + xr;
    ny = pose_y + yr;
`endif
  end

  // ---------------- sample counter ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   cnt <= '0;
    else if (clear_pose || tick) cnt <= '0;
    else                         cnt <= cnt + CNT_W'(1);
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      pose_valid <= 1'b0;
      pose_x     <= '0;
      pose_y     <= '0;
      pose_theta <= '0;
      prev_l     <= '0;
      prev_r     <= '0;
      dl         <= '0;
      dr         <= '0;
      d          <= '0;
      dth        <= '0;
      th_new     <= '0;
      cx         <= '0;
      cy         <= '0;
      cz         <= '0;
      neg        <= 1'b0;
      it         <= '0;
`ifdef POSE_SATURATE_EN
      pose_sat   <= 1'b0;
`endif
    end else if (clear_pose) begin
      // Wins over an ACC update in the same cycle.
      state      <= IDLE;
      busy       <= 1'b0;
      pose_valid <= 1'b0;
      pose_x     <= '0;
      pose_y     <= '0;
      pose_theta <= '0;
      prev_l     <= distance_pulse_left;
      prev_r     <= distance_pulse_right;
`ifdef POSE_SATURATE_EN
      pose_sat   <= 1'b0;
`endif
    end else begin
      pose_valid <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          state <= SAMPLE;
          busy  <= 1'b1;
        end
        SAMPLE: begin
          // Modular subtraction keeps counter wrap harmless.
          dl     <= distance_pulse_left - prev_l;
          dr     <= distance_pulse_right - prev_r;
          prev_l <= distance_pulse_left;
          prev_r <= distance_pulse_right;
          state  <= DELTA;
        end
        DELTA: begin
          d     <= d_c;
          dth   <= dth_c;
          state <= PREP;
        end
        PREP: begin
          th_new <= th_new_c;
          cx     <= x0;
          cy     <= '0;
          cz     <= z0;
          neg    <= fold;
          it     <= '0;
          state  <= ROT;
        end
        ROT: begin
          if (!cz[39]) begin
            cx <= cx - sx;
            cy <= cy + sy;
            cz <= cz - at;
          end else begin
            cx <= cx + sx;
            cy <= cy - sy;
            cz <= cz + at;
          end
          it <= it + 5'd1;
          if (it == 5'(CORDIC_ITER - 1)) state <= ACC;
        end
        ACC: begin
          pose_x     <= nx;
          pose_y     <= ny;
          pose_theta <= th_new;
          pose_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
`ifdef POSE_SATURATE_EN
          if (hit_x || hit_y) pose_sat <= 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_odometry_pose_integrator.sv
// Directed bench for odometry_pose_integrator with SAMPLE_CYCLES=32.
// CORDIC outputs are checked against hand-derived geometry with the
// per-update error allowance (2 mm per update, accumulating).
module tb_odometry_pose_integrator;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_l, in_r;
  logic        clear_pose;
  logic [31:0] pose_x, pose_y, pose_theta;
  logic        pose_valid, busy;
`ifdef POSE_SATURATE_EN
  logic        pose_sat;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  odometry_pose_integrator #(.SAMPLE_CYCLES(32)) dut (
    .clk                  (clk),
    .reset                (reset),
    .distance_pulse_left  (in_l),
    .distance_pulse_right (in_r),
    .clear_pose           (clear_pose),
    .pose_x               (pose_x),
    .pose_y               (pose_y),
    .pose_theta           (pose_theta),
    .pose_valid           (pose_valid),
    .busy                 (busy)
`ifdef POSE_SATURATE_EN
    ,
    .pose_sat             (pose_sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    n_chk++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic longint sx32(input logic [31:0] v);
    return longint'($signed(v));
  endfunction

  task automatic wait_valid(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      seen = pose_valid;
    end
    chk("valid_seen", longint'(seen), 1, 0);
  endtask

  task automatic step(input int sl, input int sr, output int cyc);
    in_l = in_l + 32'(sl);
    in_r = in_r + 32'(sr);
    wait_valid(cyc);
  endtask

  task automatic do_clear();
    clear_pose = 1'b1;
    @(posedge clk); #1;
    clear_pose = 1'b0;
  endtask

  // Return a few cycles into ROT (busy seen in SAMPLE, then DELTA, PREP, ROT0, ROT1).
  task automatic wait_in_rot();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 64 && !seen; k++) begin
      @(posedge clk); #1;
      seen = busy;
    end
    chk("busy_seen", longint'(seen), 1, 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int vcount;
    reset = 1'b1; clear_pose = 1'b0;
    in_l = 32'd628; in_r = 32'd628;
    #23;
    chk("rst_x",     sx32(pose_x), 0, 0);
    chk("rst_y",     sx32(pose_y), 0, 0);
    chk("rst_theta", sx32(pose_theta), 0, 0);
    chk("rst_valid", longint'(pose_valid), 0, 0);
    chk("rst_busy",  longint'(busy), 0, 0);
    @(negedge clk); reset = 1'b0;

    // Straight drive, 628 mm per sample (first sample from prev=0)
    wait_valid(cyc);
    chk("lat_first", cyc, 50, 0);
    chk("str1_x", sx32(pose_x), 628, 2);
    chk("str1_y", sx32(pose_y), 0, 2);
    chk("str1_th", sx32(pose_theta), 0, 0);
    step(628, 628, cyc);
    chk("period", cyc, 32, 0);
    chk("str2_x", sx32(pose_x), 1256, 4);
    chk("str2_y", sx32(pose_y), 0, 4);
    step(628, 628, cyc);
    chk("str3_x", sx32(pose_x), 1884, 6);
    chk("str3_y", sx32(pose_y), 0, 6);
    chk("str3_th", sx32(pose_theta), 0, 0);

    // Spin in place: 236*436907>>16 = 1573; second spin wraps 3146 -> -3137
    do_clear();
    chk("clr_x", sx32(pose_x), 0, 0);
    chk("clr_th", sx32(pose_theta), 0, 0);
    step(-118, 118, cyc);
    chk("lat_clear", cyc, 50, 0);
    chk("spin1_th", sx32(pose_theta), 1573, 0);
    chk("spin1_x", sx32(pose_x), 0, 0);
    chk("spin1_y", sx32(pose_y), 0, 0);
    step(-118, 118, cyc);
    chk("spin2_th", sx32(pose_theta), -3137, 0);
    // Drive at heading -3137 (fold path): x ~ -628, y ~ -3
    step(628, 628, cyc);
    chk("fold_x", sx32(pose_x), -628, 2);
    chk("fold_y", sx32(pose_y), -3, 2);
    chk("fold_th", sx32(pose_theta), -3137, 0);

    // Heading-rate clamp at +/-3141
    do_clear();
    step(-1000, 1000, cyc);
    chk("clamp_pos", sx32(pose_theta), 3141, 0);
    step(1000, -1000, cyc);
    chk("clamp_neg", sx32(pose_theta), 0, 0);

    // Build heading 1571: 233 -> 1553, then three diffs of 1 -> +6 each
    do_clear();
    step(-116, 117, cyc);
    chk("h_a", sx32(pose_theta), 1553, 0);
    for (int k = 0; k < 3; k++) step(0, 1, cyc);
    chk("h_1571", sx32(pose_theta), 1571, 0);
    step(628, 628, cyc);
    chk("north_y", sx32(pose_y), 628, 2);
    chk("north_x", sx32(pose_x), 0, 2);

    // Input wrap: 0xFFFFFF00 -> 0x00000174 is +628
    in_l = 32'hFFFF_FF00; in_r = 32'hFFFF_FF00;
    do_clear();
    in_l = 32'h0000_0174; in_r = 32'h0000_0174;
    wait_valid(cyc);
    chk("iwrap_x", sx32(pose_x), 628, 2);
    chk("iwrap_y", sx32(pose_y), 0, 2);

    // clear_pose during ROT; travel added after SAMPLE must be discarded
    in_l = in_l + 32'd628; in_r = in_r + 32'd628;
    wait_in_rot();
    chk("rot_busy", longint'(busy), 1, 0);
    in_l = in_l + 32'd628; in_r = in_r + 32'd628;
    do_clear();
    chk("crot_x", sx32(pose_x), 0, 0);
    chk("crot_y", sx32(pose_y), 0, 0);
    chk("crot_th", sx32(pose_theta), 0, 0);
    chk("crot_busy", longint'(busy), 0, 0);
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (pose_valid) vcount++;
      @(posedge clk); #1;
    end
    chk("crot_novalid", vcount, 0, 0);
    step(628, 628, cyc);
    chk("post_clr_x", sx32(pose_x), 628, 2);

    // Async reset mid-ROT
    in_l = in_l + 32'd628; in_r = in_r + 32'd628;
    wait_in_rot();
    #2 reset = 1'b1;
    #1;
    chk("arst_x", sx32(pose_x), 0, 0);
    chk("arst_y", sx32(pose_y), 0, 0);
    chk("arst_th", sx32(pose_theta), 0, 0);
    chk("arst_busy", longint'(busy), 0, 0);
    chk("arst_valid", longint'(pose_valid), 0, 0);
    in_l = 32'd628; in_r = 32'd628;
    @(negedge clk); reset = 1'b0;
    wait_valid(cyc);
    chk("arst_lat", cyc, 50, 0);
    chk("arst_x2", sx32(pose_x), 628, 2);

    // Large travel: two 2^30 mm steps overflow int32 (gain error ~2e-6)
    in_l = 32'd0; in_r = 32'd0;
    do_clear();
    in_l = 32'h4000_0000; in_r = 32'h4000_0000;
    wait_valid(cyc);
    chk("big1_x", sx32(pose_x), 64'sd1073741824, 4096);
`ifdef POSE_SATURATE_EN
    chk("big1_sat", longint'(pose_sat), 0, 0);
`endif
    in_l = 32'h8000_0000; in_r = 32'h8000_0000;
    wait_valid(cyc);
`ifdef POSE_SATURATE_EN
    chk("sat_x", sx32(pose_x), 64'sd2147483647, 0);
    chk("sat_flag", longint'(pose_sat), 1, 0);
`else
    chk("wrap_x", sx32(pose_x), -64'sd2147483648 + 4096, 4096);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
